axi_arbiter_r: RTL and testbench

Round-robin read-channel arbiter for the 4-master AXI interconnect. It owns the shared AR/R path to the single downstream slave port and grants it to one master per complete read transaction. The grant is held from AR handshake through the RLAST beat, and the arbiter releases the path after a configurable R-channel stall timeout. Its one-hot grants drive the AR/R muxes and demuxes in the interconnect read path.

---
 rtl/axi_arbiter_r.sv | 181 ++++++++++++++++++
 tb/tb_axi_arbiter_r.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter_r.sv
// axi_arbiter_r: round-robin owner of the shared AR/R path for four AXI read masters.
// Latency: ARVALID sampled in IDLE -> registered one-hot grant the next cycle; one dead cycle between transactions.
// Backpressure: grant held from AR handshake through RLAST; forced release after TIMEOUT R-stall cycles (0 = never).
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   m*_ARVALID, m*_RREADY   per-master read-address request / read-data ready
//   s_ARREADY, s_RVALID,    downstream slave handshake signals
//   s_RLAST
//   m*_rgrnt                registered one-hot grant (all 0 when idle)
//   rgrnt_id                index of current or most recent owner
//   busy                    high while a transaction owns the path
//   beat_cnt                R beats accepted in the current transaction (saturating)
//   timeout_err             one-cycle pulse on forced release
//
// CNT_W must satisfy 2**CNT_W > TIMEOUT.
module axi_arbiter_r #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       m0_ARVALID,
  input  logic       m1_ARVALID,
  input  logic       m2_ARVALID,
  input  logic       m3_ARVALID,
  input  logic       m0_RREADY,
  input  logic       m1_RREADY,
  input  logic       m2_RREADY,
  input  logic       m3_RREADY,
  input  logic       s_ARREADY,
  input  logic       s_RVALID,
  input  logic       s_RLAST,
  output logic       m0_rgrnt,
  output logic       m1_rgrnt,
  output logic       m2_rgrnt,
  output logic       m3_rgrnt,
  output logic [1:0] rgrnt_id,
  output logic       busy,
  output logic [7:0] beat_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Stall count at which the next silent cycle triggers the forced release.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       arvalid;
  logic [3:0]       rready;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       id_q, id_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [7:0]       beat_q, beat_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             terr_q, terr_d;

  logic [1:0]       sel;
  logic             sel_found;
  logic             r_hs;

  assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
  assign rready  = {m3_RREADY, m2_RREADY, m1_RREADY, m0_RREADY};

  // First requester searching upward from ptr, wrapping mod 4.
  always_comb begin
    sel       = 2'd0;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sel_found && arvalid[ptr_q + i[1:0]]) begin
        sel       = ptr_q + i[1:0];
        sel_found = 1'b1;
      end
    end
  end

  assign r_hs = s_RVALID && rready[owner_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    id_d    = id_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    terr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          owner_d = sel;
          id_d    = sel;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (arvalid[owner_q] && s_ARREADY) begin
          state_d = S_DATA;
          beat_d  = 8'd0;
          stall_d = '0;
        end else if (!arvalid[owner_q]) begin
          // Owner withdrew its request before the handshake: release without
          // advancing the priority pointer.
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        if (r_hs) begin
          // A handshake always beats a coincident timeout.
          beat_d  = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
          stall_d = '0;
          if (s_RLAST) begin
            state_d = S_IDLE;
            ptr_d   = owner_q + 2'd1;
          end
        end else begin
          // Saturate so a disabled timeout never wraps the counter.
          stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (stall_q == TO_LAST)) begin
            state_d = S_IDLE;
            ptr_d   = owner_q + 2'd1;
            terr_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Grant and busy are registered from the next state and next owner only.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    grant_d = busy_d ? (4'b0001 << owner_d) : 4'b0000;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      id_q    <= 2'd0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      beat_q  <= 8'd0;
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end

  assign m0_rgrnt    = grant_q[0];
  assign m1_rgrnt    = grant_q[1];
  assign m2_rgrnt    = grant_q[2];
  assign m3_rgrnt    = grant_q[3];
  assign rgrnt_id    = id_q;
  assign busy        = busy_q;
  assign beat_cnt    = beat_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_axi_arbiter_r.sv
// tb_axi_arbiter_r: directed bench for axi_arbiter_r with TIMEOUT=256, 8 and 0 instances.
// Latency: inputs driven 1ns after each rising edge, outputs sampled at the same point.
// Backpressure: stall and timeout scenarios drive RREADY/RVALID low for fixed cycle counts.
module tb_axi_arbiter_r;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic [3:0] arv = 4'b0000;
  logic [3:0] rrdy = 4'b0000;
  logic       s_ARREADY = 1'b0;
  logic       s_RVALID = 1'b0;
  logic       s_RLAST = 1'b0;

  wire [3:0] a_g, b_g, c_g;
  wire [1:0] a_id, b_id, c_id;
  wire       a_busy, b_busy, c_busy;
  wire [7:0] a_beat, b_beat, c_beat;
  wire       a_terr, b_terr, c_terr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  axi_arbiter_r #(.TIMEOUT(256), .CNT_W(9)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARVALID(arv[0]), .m1_ARVALID(arv[1]), .m2_ARVALID(arv[2]), .m3_ARVALID(arv[3]),
    .m0_RREADY(rrdy[0]), .m1_RREADY(rrdy[1]), .m2_RREADY(rrdy[2]), .m3_RREADY(rrdy[3]),
    .s_ARREADY(s_ARREADY), .s_RVALID(s_RVALID), .s_RLAST(s_RLAST),
    .m0_rgrnt(a_g[0]), .m1_rgrnt(a_g[1]), .m2_rgrnt(a_g[2]), .m3_rgrnt(a_g[3]),
    .rgrnt_id(a_id), .busy(a_busy), .beat_cnt(a_beat), .timeout_err(a_terr)
  );

  axi_arbiter_r #(.TIMEOUT(8), .CNT_W(4)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARVALID(arv[0]), .m1_ARVALID(arv[1]), .m2_ARVALID(arv[2]), .m3_ARVALID(arv[3]),
    .m0_RREADY(rrdy[0]), .m1_RREADY(rrdy[1]), .m2_RREADY(rrdy[2]), .m3_RREADY(rrdy[3]),
    .s_ARREADY(s_ARREADY), .s_RVALID(s_RVALID), .s_RLAST(s_RLAST),
    .m0_rgrnt(b_g[0]), .m1_rgrnt(b_g[1]), .m2_rgrnt(b_g[2]), .m3_rgrnt(b_g[3]),
    .rgrnt_id(b_id), .busy(b_busy), .beat_cnt(b_beat), .timeout_err(b_terr)
  );

  axi_arbiter_r #(.TIMEOUT(0), .CNT_W(4)) dut_c (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARVALID(arv[0]), .m1_ARVALID(arv[1]), .m2_ARVALID(arv[2]), .m3_ARVALID(arv[3]),
    .m0_RREADY(rrdy[0]), .m1_RREADY(rrdy[1]), .m2_RREADY(rrdy[2]), .m3_RREADY(rrdy[3]),
    .s_ARREADY(s_ARREADY), .s_RVALID(s_RVALID), .s_RLAST(s_RLAST),
    .m0_rgrnt(c_g[0]), .m1_rgrnt(c_g[1]), .m2_rgrnt(c_g[2]), .m3_rgrnt(c_g[3]),
    .rgrnt_id(c_id), .busy(c_busy), .beat_cnt(c_beat), .timeout_err(c_terr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    arv       = 4'b0000;
    rrdy      = 4'b0000;
    s_ARREADY = 1'b0;
    s_RVALID  = 1'b0;
    s_RLAST   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  initial begin
    logic       terr_seen;
    logic       grant_lost;
    logic [3:0] exp_g;

    // ---------------- reset + single 4-beat read by master 2
    do_reset();
    check("rst_grant", a_g, 4'b0000);
    check("rst_id", a_id, 2'd0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_beat", a_beat, 8'd0);
    check("rst_terr", a_terr, 1'b0);

    arv = 4'b0100;
    tick();
    check("s1_grant", a_g, 4'b0100);
    check("s1_id", a_id, 2'd2);
    check("s1_busy", a_busy, 1'b1);

    s_ARREADY = 1'b1;
    tick();
    check("s1_data_grant", a_g, 4'b0100);
    check("s1_beat0", a_beat, 8'd0);
    arv = 4'b0000;
    s_ARREADY = 1'b0;
    rrdy = 4'b0100;
    s_RVALID = 1'b1;
    terr_seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      terr_seen |= a_terr;
      check($sformatf("s1_beat%0d", i), a_beat, i);
      check($sformatf("s1_hold%0d", i), a_g, 4'b0100);
    end
    s_RLAST = 1'b1;
    tick();
    terr_seen |= a_terr;
    check("s1_done_grant", a_g, 4'b0000);
    check("s1_done_busy", a_busy, 1'b0);
    check("s1_done_beat", a_beat, 8'd4);
    check("s1_done_id", a_id, 2'd2);
    idle_inputs();
    tick();
    terr_seen |= a_terr;
    check("s1_beat_hold_idle", a_beat, 8'd4);
    check("s1_no_terr", terr_seen, 1'b0);

    // ---------------- wrap: ptr=3, m0 and m1 request -> m0 then m1
    arv = 4'b0011;
    tick();
    check("wrap_m0", a_g, 4'b0001);
    check("wrap_m0_id", a_id, 2'd0);
    s_ARREADY = 1'b1;
    tick();
    s_ARREADY = 1'b0;
    arv = 4'b0010;
    rrdy = 4'b0001;
    s_RVALID = 1'b1;
    s_RLAST = 1'b1;
    tick();
    check("wrap_m0_done", a_g, 4'b0000);
    check("wrap_m0_beat", a_beat, 8'd1);
    s_RVALID = 1'b0;
    s_RLAST = 1'b0;
    rrdy = 4'b0000;
    tick();
    check("wrap_m1", a_g, 4'b0010);
    check("wrap_m1_id", a_id, 2'd1);
    s_ARREADY = 1'b1;
    tick();
    idle_inputs();
    rrdy = 4'b0010;
    s_RVALID = 1'b1;
    s_RLAST = 1'b1;
    tick();
    check("wrap_m1_done", a_g, 4'b0000);
    idle_inputs();

    // ---------------- ADDR abort keeps ptr (ptr is 2 here)
    arv = 4'b0100;
    tick();
    check("abort_grant", a_g, 4'b0100);
    arv = 4'b0000;
    tick();
    check("abort_release", a_g, 4'b0000);
    check("abort_busy", a_busy, 1'b0);
    arv = 4'b1100;
    tick();
    check("abort_ptr_kept", a_g, 4'b0100);
    arv = 4'b0000;
    tick();

    // ---------------- round-robin: everything asserted, single-beat reads
    do_reset();
    arv = 4'b1111;
    rrdy = 4'b1111;
    s_ARREADY = 1'b1;
    s_RVALID = 1'b1;
    s_RLAST = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_g = ((k % 3) == 0) ? 4'b0000 : (4'b0001 << (((k - 1) / 3) % 4));
      check($sformatf("rr_cyc%0d", k), a_g, exp_g);
    end
    idle_inputs();

    // ---------------- backpressure: 50 stall cycles, TIMEOUT=256
    do_reset();
    arv = 4'b0010;
    tick();
    s_ARREADY = 1'b1;
    tick();
    arv = 4'b0000;
    s_ARREADY = 1'b0;
    rrdy = 4'b0010;
    s_RVALID = 1'b1;
    tick();
    tick();
    check("bp_beat2", a_beat, 8'd2);
    rrdy = 4'b0000;
    terr_seen = 1'b0;
    grant_lost = 1'b0;
    repeat (50) begin
      tick();
      terr_seen |= a_terr;
      grant_lost |= (a_g != 4'b0010);
    end
    check("bp_no_terr", terr_seen, 1'b0);
    check("bp_grant_held", grant_lost, 1'b0);
    check("bp_beat_frozen", a_beat, 8'd2);
    rrdy = 4'b0010;
    tick();
    check("bp_beat3", a_beat, 8'd3);
    s_RLAST = 1'b1;
    tick();
    check("bp_beat4", a_beat, 8'd4);
    check("bp_done", a_g, 4'b0000);
    idle_inputs();

    // ---------------- timeout: TIMEOUT=8 instance and TIMEOUT=0 instance
    do_reset();
    arv = 4'b0001;
    tick();
    check("to_grant", b_g, 4'b0001);
    s_ARREADY = 1'b1;
    tick();                             // AR handshake was cycle T; now T+1
    s_ARREADY = 1'b0;
    arv = 4'b0100;
    check("to_t1_grant", b_g, 4'b0001);
    terr_seen = 1'b0;
    grant_lost = 1'b0;
    repeat (7) begin                    // T+2 .. T+8
      tick();
      terr_seen |= b_terr;
      grant_lost |= (b_g != 4'b0001);
    end
    check("to_early_terr", terr_seen, 1'b0);
    check("to_early_hold", grant_lost, 1'b0);
    tick();                             // T+9
    check("to_terr_pulse", b_terr, 1'b1);
    check("to_grant_clr", b_g, 4'b0000);
    check("to_busy_clr", b_busy, 1'b0);
    tick();                             // T+10
    check("to_terr_one_cycle", b_terr, 1'b0);
    check("to_next_grant", b_g, 4'b0100);
    check("to_next_id", b_id, 2'd2);
    check("to0_hold_t10", c_g, 4'b0001);
    terr_seen = 1'b0;
    grant_lost = 1'b0;
    repeat (300) begin
      tick();
      terr_seen |= c_terr;
      grant_lost |= (c_g != 4'b0001);
    end
    check("to0_no_terr", terr_seen, 1'b0);
    check("to0_hold_long", grant_lost, 1'b0);
    check("to0_busy", c_busy, 1'b1);
    idle_inputs();

    // ---------------- asynchronous reset mid-DATA
    do_reset();
    arv = 4'b0100;
    tick();
    s_ARREADY = 1'b1;
    tick();
    arv = 4'b0000;
    s_ARREADY = 1'b0;
    rrdy = 4'b0100;
    s_RVALID = 1'b1;
    tick();
    tick();
    check("ar_pre_beat", a_beat, 8'd2);
    check("ar_pre_grant", a_g, 4'b0100);
    s_RVALID = 1'b0;
    #3;
    ARESET = 1'b1;
    #1;
    check("ar_grant", a_g, 4'b0000);
    check("ar_busy", a_busy, 1'b0);
    check("ar_beat", a_beat, 8'd0);
    check("ar_id", a_id, 2'd0);
    #2;
    ARESET = 1'b0;
    arv = 4'b1111;
    tick();
    check("ar_m0_wins", a_g, 4'b0001);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
